tc4_seg_arbiter: RTL
====================

// Module: tc4_seg_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 4-bit two's-complement-to-7-segment converter among NREQ requesters.
//  Each requester posts a 4-bit TC value with a req/ack handshake.
//  The block drives the converter's N input and captures its Sign/Magnitude outputs.
//  The captured patterns go into per-requester display registers that feed HEX-digit pairs on the board.
// PARAMETERS
//  NREQ   4   number of requesters, legal range 2..8
//  IDW    2   grant-id width, must equal clog2(NREQ)
// PORTS
//  Clock          in   1         single system clock, rising edge
//  Reset          in   1         asynchronous, active-high reset
//  Req            in   NREQ      level request, one bit per requester
//  Value          in   4*NREQ    TC value of requester i at [4i+3:4i]
//  Ack            out  NREQ      one-cycle completion pulse, one-hot
//  Busy           out  1         high while state != IDLE
//  GntId          out  IDW       index of requester being served
//  ConvN          out  4         to converter N input
//  ConvSign       in   7         from converter Sign output (active-low)
//  ConvMag        in   7         from converter Magnitude output (active-low)
//  HexSign        out  7*NREQ    latched sign pattern, requester i at [7i+6:7i]
//  HexMag         out  7*NREQ    latched magnitude pattern, requester i at [7i+6:7i]
// BEHAVIOUR
//  Reset (async, immediate) values:
//   - state IDLE; Ack=0; Busy=0; GntId=0; ConvN=0; priority pointer=0.
//   - every HexSign/HexMag slice = 7'h7F (all segments off, blank).
//  FSM states: IDLE -> GRANT -> CAPTURE -> IDLE. One clock per state.
//  IDLE:
//   - If any Req is high, pick the first set bit at or after the pointer, wrapping modulo NREQ.
//   - At the edge: GntId=winner, ConvN=Value[winner] (latched), go to GRANT.
//   - If no Req is high, stay in IDLE.
//  GRANT:
//   - ConvN holds the latched value; later changes on Value are ignored.
//   - The converter is combinational and settles within this cycle.
//   - If Req[GntId] is still high at the edge:
//     - load HexSign/HexMag slice GntId from ConvSign/ConvMag;
//     - set Ack[GntId]=1;
//     - go to CAPTURE.
//   - If Req[GntId] has dropped (abort): go to IDLE; no display update; no Ack; pointer unchanged.
//  CAPTURE:
//   - Ack[GntId] is high for exactly this cycle, and the new display slice is visible this cycle.
//   - At the edge: Ack=0, pointer=(GntId+1) mod NREQ, go to IDLE.
//  Timing:
//   - Latency from Req seen in IDLE to Ack is 2 edges; transaction period is 3 cycles.
//   - Back-to-back service of different requesters is one transaction per 3 cycles.
//  Requester handshake:
//   - Hold Req and Value until Ack.
//   - A Req still high in the cycle after Ack is treated as a new request.
//   - Because the pointer has advanced, other pending requesters win first (no starvation).
//  Display slices of non-granted requesters never change.
//  Display values persist indefinitely until rewritten or Reset.
//  ConvN holds its last value while in IDLE.
//  Reset asserted mid-transaction aborts it: no Ack is issued and all displays blank.
// TESTING
//  1. Reset -> all HexSign/HexMag = 7'h7F, Ack=0, Busy=0, ConvN=0.
//  2. Req[0]=1, Value0=4'b1101 (-3) -> Ack[0] pulses at the 2nd edge; HexSign0=7'b0111111, HexMag0=7'b0110000.
//  3. Req=4'b1111 with values 5,-8,0,7, pointer=0 -> Acks in order 0,1,2,3, spaced 3 cycles apart:
//     - HexMag = 7'b0010010, 7'b0000000, 7'b1000000, 7'b1111000;
//     - HexSign1 = 7'b0111111, all other HexSign = 7'h7F.
//  4. Req[2] is dropped during GRANT -> no Ack, HexMag2 unchanged, next IDLE arbitration still starts at the pointer.
//  5. Req[1] is held high after its Ack while Req[3] is high -> requester 3 is served before requester 1 again.
//  6. Reset is asserted during CAPTURE -> Ack deasserts immediately and all displays return to 7'h7F.

Source files
------------

// File: rtl/tc4_seg_arbiter.sv
// Round-robin arbiter that shares one external 4-bit two's-complement to 7-segment
// converter among NREQ requesters and latches each result into a per-requester display slice.
module tc4_seg_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [NREQ-1:0]     Req,
  input  logic [4*NREQ-1:0]   Value,
  output logic [NREQ-1:0]     Ack,
  output logic                Busy,
  output logic [IDW-1:0]      GntId,
  output logic [3:0]          ConvN,
  input  logic [6:0]          ConvSign,
  input  logic [6:0]          ConvMag,
  output logic [7*NREQ-1:0]   HexSign,
  output logic [7*NREQ-1:0]   HexMag
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    CAPTURE
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_inc;
  logic [IDW-1:0] winner;
  logic           any_req;

  // Rotating search: first set Req bit at or after ptr, wrapping modulo NREQ.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any_req && Req[(32'(ptr) + i) % NREQ]) begin
        any_req = 1'b1;
        winner  = IDW'((32'(ptr) + i) % NREQ);
      end
    end
  end

  always_comb begin
    if (GntId == IDW'(NREQ - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = GntId + IDW'(1);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = GRANT;
      GRANT:   state_nxt = Req[GntId] ? CAPTURE : IDLE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ack is decoded from state so an async reset drops it immediately.
  always_comb begin
    Ack  = '0;
    Busy = (state != IDLE);
    if (state == CAPTURE) begin
      Ack[GntId] = 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      GntId   <= '0;
      ConvN   <= '0;
      ptr     <= '0;
      HexSign <= '1;
      HexMag  <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            GntId <= winner;
            ConvN <= Value[4*winner +: 4];
          end
        end
        GRANT: begin
          if (Req[GntId]) begin
            HexSign[7*GntId +: 7] <= ConvSign;
            HexMag[7*GntId +: 7]  <= ConvMag;
          end
        end
        CAPTURE: begin
          ptr <= ptr_inc;
        end
        default: ;
      endcase
    end
  end

endmodule
